alu_op_sequencer: RTL and testbench

//  Multi-cycle initiator for the combinational alu: accepts a macro-op (NOT/AND/SUB/MUL),

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu.sv | 38 +++
 rtl/alu_seq_step.sv | 106 ++++++++++
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu command, sequencer op/state and datapath select types
//
// Purpose: types and constants used by the alu, the op sequencer and its step decoder.
// Ports: none (package).
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_NAND = 2'b00,
    ALU_ROR  = 2'b01,
    ALU_ADD  = 2'b10
  } alu_cmd_e;

  typedef enum logic [1:0] {
    SEQ_NOT = 2'b00,
    SEQ_AND = 2'b01,
    SEQ_SUB = 2'b10,
    SEQ_MUL = 2'b11
  } seq_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Operand sources feeding alu inA/inB.
  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_A    = 3'd1,
    SRC_B    = 3'd2,
    SRC_TMP  = 3'd3,
    SRC_ACC  = 3'd4,
    SRC_ASH  = 3'd5,
    SRC_ONE  = 3'd6
  } src_sel_e;

  // Register that captures the alu result at the end of a step.
  typedef enum logic [1:0] {
    DST_RES = 2'b00,
    DST_TMP = 2'b01,
    DST_ACC = 2'b10,
    DST_ASH = 2'b11
  } dst_sel_e;

  // Step counts per op; MUL is 2 * MUL_ITER and is derived where that parameter lives.
  localparam int NOT_STEPS = 1;
  localparam int AND_STEPS = 2;
  localparam int SUB_STEPS = 3;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 8-bit alu (NAND / ROR / ADD) driven by the op sequencer
//
// Purpose: single-cycle responder; the sequencer builds NOT/AND/SUB/MUL from these primitives.
// Ports:
//   inA, inB  in  [7:0]  operands
//   cmd       in  [1:0]  00 NAND, 01 ROR (through sc_i), 10 ADD (with sc_i carry-in)
//   sc_i      in         carry / rotate-in
//   rslt      out [7:0]  result
//   sc_o      out        carry-out (ADD) or rotated-out bit (ROR)
module alu
  import alu_pkg::*;
(
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic [1:0] cmd,
  input  logic       sc_i,
  output logic [7:0] rslt,
  output logic       sc_o
);

  always_comb begin
    rslt = 8'h00;
    sc_o = 1'b0;
    case (cmd)
      ALU_NAND: rslt = ~(inA & inB);
      ALU_ROR: begin
        rslt = {sc_i, inA[7:1]};
        sc_o = inA[0];
      end
      ALU_ADD: {sc_o, rslt} = {1'b0, inA} + {1'b0, inB} + {8'h00, sc_i};
      default: begin
        rslt = 8'h00;
        sc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_step.sv
// rtl/alu_seq_step.sv - per-step microcode decoder for the alu op sequencer
//
// Purpose: maps (op, step, b_sh[0]) to the alu command, operand sources and capture target.
// Ports:
//   op       in  [1:0]  latched macro-op
//   step     in  [3:0]  current step index
//   b_lsb    in         b_sh[0], gates MUL accumulation
//   cmd      out [1:0]  alu command for this step
//   a_sel    out [2:0]  inA source
//   b_sel    out [2:0]  inB source
//   dst      out [1:0]  register that captures rslt
//   wr_en    out        capture enable
//   last     out        this is the final step of the op
module alu_seq_step
  import alu_pkg::*;
#(
  parameter int MUL_ITER = 8
) (
  input  seq_op_e    op,
  input  logic [3:0] step,
  input  logic       b_lsb,
  output alu_cmd_e   cmd,
  output src_sel_e   a_sel,
  output src_sel_e   b_sel,
  output dst_sel_e   dst,
  output logic       wr_en,
  output logic       last
);

  localparam logic [3:0] NOT_LAST = 4'(NOT_STEPS - 1);
  localparam logic [3:0] AND_LAST = 4'(AND_STEPS - 1);
  localparam logic [3:0] SUB_LAST = 4'(SUB_STEPS - 1);
  localparam logic [3:0] MUL_LAST = 4'(2 * MUL_ITER - 1);

  always_comb begin
    cmd   = ALU_NAND;
    a_sel = SRC_ZERO;
    b_sel = SRC_ZERO;
    dst   = DST_RES;
    wr_en = 1'b0;
    last  = 1'b0;
    case (op)
      SEQ_NOT: begin
        a_sel = SRC_A;
        b_sel = SRC_A;
        wr_en = 1'b1;
        last  = (step == NOT_LAST);
      end
      SEQ_AND: begin
        wr_en = 1'b1;
        last  = (step == AND_LAST);
        if (step == 4'd0) begin
          a_sel = SRC_A;
          b_sel = SRC_B;
          dst   = DST_TMP;
        end else begin
          a_sel = SRC_TMP;
          b_sel = SRC_TMP;
        end
      end
      SEQ_SUB: begin
        // a - b computed as a + (~b + 1).
        wr_en = 1'b1;
        last  = (step == SUB_LAST);
        case (step)
          4'd0: begin
            a_sel = SRC_B;
            b_sel = SRC_B;
            dst   = DST_TMP;
          end
          4'd1: begin
            cmd   = ALU_ADD;
            a_sel = SRC_TMP;
            b_sel = SRC_ONE;
            dst   = DST_TMP;
          end
          default: begin
            cmd   = ALU_ADD;
            a_sel = SRC_A;
            b_sel = SRC_TMP;
          end
        endcase
      end
      SEQ_MUL: begin
        // Even steps conditionally accumulate, odd steps double the shifted multiplicand.
        cmd  = ALU_ADD;
        last = (step == MUL_LAST);
        if (!step[0]) begin
          a_sel = SRC_ACC;
          b_sel = SRC_ASH;
          dst   = DST_ACC;
          wr_en = b_lsb;
        end else begin
          a_sel = SRC_ASH;
          b_sel = SRC_ASH;
          dst   = DST_ASH;
          wr_en = 1'b1;
        end
      end
      default: begin
        cmd = ALU_NAND;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - multi-cycle NOT/AND/SUB/MUL initiator driving one external alu
//
// Purpose: accepts a macro-op, steps the alu through its primitive sequence, returns result.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start, op, a, b         request (accepted only in IDLE), op code, operands
//   busy, done              EXEC indicator, one-cycle completion pulse
//   result, zero_o          final value (held) and its zero flag
//   alu_cmd_o/a_o/b_o/sc_o  alu request bus (quiet outside EXEC; sc always 0)
//   alu_rslt_i              alu result, captured at the end of each step
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int W        = 8,
  parameter int MUL_ITER = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         zero_o,
  output logic [1:0]   alu_cmd_o,
  output logic [W-1:0] alu_a_o,
  output logic [W-1:0] alu_b_o,
  output logic         alu_sc_o,
  input  logic [W-1:0] alu_rslt_i
);

  seq_state_e   state_q, state_d;
  seq_op_e      op_q;
  logic [W-1:0] a_q, b_q, tmp_q, acc_q, a_sh_q, b_sh_q;
  logic [3:0]   step_q;

  alu_cmd_e     step_cmd;
  src_sel_e     step_a_sel, step_b_sel;
  dst_sel_e     step_dst;
  logic         step_wr_en, step_last;
  logic [W-1:0] src_a_val, src_b_val;

  alu_seq_step #(.MUL_ITER(MUL_ITER)) u_step (
    .op    (op_q),
    .step  (step_q),
    .b_lsb (b_sh_q[0]),
    .cmd   (step_cmd),
    .a_sel (step_a_sel),
    .b_sel (step_b_sel),
    .dst   (step_dst),
    .wr_en (step_wr_en),
    .last  (step_last)
  );

  function automatic logic [W-1:0] pick(input src_sel_e sel, input logic [W-1:0] av,
                                        input logic [W-1:0] bv, input logic [W-1:0] tv,
                                        input logic [W-1:0] cv, input logic [W-1:0] sv);
    case (sel)
      SRC_A:   return av;
      SRC_B:   return bv;
      SRC_TMP: return tv;
      SRC_ACC: return cv;
      SRC_ASH: return sv;
      SRC_ONE: return W'(1);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    src_a_val = pick(step_a_sel, a_q, b_q, tmp_q, acc_q, a_sh_q);
    src_b_val = pick(step_b_sel, a_q, b_q, tmp_q, acc_q, a_sh_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    alu_cmd_o = ALU_NAND;
    alu_a_o   = '0;
    alu_b_o   = '0;
    alu_sc_o  = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = EXEC;
      EXEC: begin
        busy      = 1'b1;
        alu_cmd_o = step_cmd;
        alu_a_o   = src_a_val;
        alu_b_o   = src_b_val;
        if (step_last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q   <= SEQ_NOT;
      a_q    <= '0;
      b_q    <= '0;
      tmp_q  <= '0;
      acc_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      step_q <= '0;
      result <= '0;
      zero_o <= 1'b1;
    end else if (state_q == IDLE && start) begin
      op_q   <= seq_op_e'(op);
      a_q    <= a;
      b_q    <= b;
      tmp_q  <= '0;
      acc_q  <= '0;
      a_sh_q <= a;
      b_sh_q <= b;
      step_q <= '0;
    end else if (state_q == EXEC) begin
      if (step_wr_en) begin
        case (step_dst)
          DST_TMP: tmp_q  <= alu_rslt_i;
          DST_ACC: acc_q  <= alu_rslt_i;
          DST_ASH: a_sh_q <= alu_rslt_i;
          default: begin
            result <= alu_rslt_i;
            zero_o <= (alu_rslt_i == '0);
          end
        endcase
      end
      if (op_q == SEQ_MUL && step_q[0]) b_sh_q <= b_sh_q >> 1;
      if (step_last) begin
        step_q <= '0;
        // MUL's final step only doubles a_sh; the product is already complete in acc.
        if (op_q == SEQ_MUL) begin
          result <= acc_q;
          zero_o <= (acc_q == '0);
        end
      end else begin
        step_q <= step_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer with a real alu
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       reset_n, start;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       busy, done, zero_o, alu_sc_o, alu_sc_out;
  logic [7:0] result, alu_a_o, alu_b_o, alu_rslt;
  logic [1:0] alu_cmd_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(8), .MUL_ITER(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero_o(zero_o),
    .alu_cmd_o(alu_cmd_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_sc_o(alu_sc_o), .alu_rslt_i(alu_rslt)
  );

  alu u_alu (
    .inA(alu_a_o), .inB(alu_b_o), .cmd(alu_cmd_o), .sc_i(alu_sc_o),
    .rslt(alu_rslt), .sc_o(alu_sc_out)
  );

  task automatic issue(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
  endtask

  // Returns the cycle (start cycle = 0) in which done is seen, -1 on timeout;
  // bad is set if busy was low before done or busy and done overlapped.
  task automatic wait_done(input int budget, output int cyc, output bit bad);
    cyc = -1;
    bad = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy && done) bad = 1'b1;
      if (done) begin
        cyc = n;
        break;
      end
      if (!busy) bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, result, zero_o} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_state got busy=%b done=%b result=%h zero=%b want 0 0 00 1",
               busy, done, result, zero_o);
    end
    tests_run++;
    if ({alu_cmd_o, alu_a_o, alu_b_o, alu_sc_o} !== 19'h0) begin
      tests_failed++;
      $display("FAIL reset_bus got cmd=%b a=%h b=%h sc=%b want all 0",
               alu_cmd_o, alu_a_o, alu_b_o, alu_sc_o);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_not();
    int cyc;
    issue(2'b00, 8'h5A, 8'h00);
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if ({busy, alu_cmd_o, alu_a_o, alu_b_o} !== {1'b1, 2'b00, 8'h5A, 8'h5A}) begin
      tests_failed++;
      $display("FAIL not_step0_bus got busy=%b cmd=%b a=%h b=%h want 1 00 5a 5a",
               busy, alu_cmd_o, alu_a_o, alu_b_o);
    end
    @(negedge clk);
    cyc = done ? 2 : -1;
    tests_run++;
    if (cyc !== 2 || result !== 8'hA5 || zero_o !== 1'b0 || busy !== 1'b0
        || alu_a_o !== 8'h00 || alu_cmd_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL not_5a got cyc=%0d result=%h zero=%b busy=%b bus_a=%h want 2 a5 0 0 00",
               cyc, result, zero_o, busy, alu_a_o);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 8'hA5) begin
      tests_failed++;
      $display("FAIL not_after got done=%b busy=%b result=%h want 0 0 a5", done, busy, result);
    end
  endtask

  task automatic test_and();
    int cyc;
    bit bad;
    issue(2'b01, 8'hF0, 8'h3C);
    wait_done(40, cyc, bad);
    tests_run++;
    if (cyc !== 3 || bad || result !== 8'h30 || zero_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL and_f0_3c got cyc=%0d bad=%b result=%h zero=%b want 3 0 30 0",
               cyc, bad, result, zero_o);
    end
  endtask

  task automatic test_sub();
    logic [7:0] sa [3] = '{8'h10, 8'h00, 8'h77};
    logic [7:0] sb [3] = '{8'h01, 8'h01, 8'h77};
    logic [7:0] sr [3] = '{8'h0F, 8'hFF, 8'h00};
    logic       sz [3] = '{1'b0, 1'b0, 1'b1};
    int cyc;
    bit bad;
    for (int i = 0; i < 3; i++) begin
      issue(2'b10, sa[i], sb[i]);
      wait_done(40, cyc, bad);
      tests_run++;
      if (cyc !== 4 || bad || result !== sr[i] || zero_o !== sz[i]) begin
        tests_failed++;
        $display("FAIL sub_%h_%h got cyc=%0d bad=%b result=%h zero=%b want 4 0 %h %b",
                 sa[i], sb[i], cyc, bad, result, zero_o, sr[i], sz[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [7:0] ma [2] = '{8'd13, 8'h10};
    logic [7:0] mb [2] = '{8'd11, 8'h20};
    logic [7:0] mr [2] = '{8'h8F, 8'h00};
    logic       mz [2] = '{1'b0, 1'b1};
    int cyc;
    bit bad;
    for (int i = 0; i < 2; i++) begin
      issue(2'b11, ma[i], mb[i]);
      wait_done(40, cyc, bad);
      tests_run++;
      if (cyc !== 17 || bad || result !== mr[i] || zero_o !== mz[i]) begin
        tests_failed++;
        $display("FAIL mul_%h_%h got cyc=%0d bad=%b result=%h zero=%b want 17 0 %h %b",
                 ma[i], mb[i], cyc, bad, result, zero_o, mr[i], mz[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int first = -1;
    logic [7:0] res_at_done = 8'h00;
    issue(2'b11, 8'd13, 8'd11);
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 5) begin start = 1'b1; op = 2'b00; a = 8'h5A; b = 8'h00; end
      if (n == 6) begin start = 1'b0; a = 8'h00; end
      if (done) begin
        dones++;
        if (first < 0) begin first = n; res_at_done = result; end
      end
    end
    tests_run++;
    if (dones !== 1 || first !== 17 || res_at_done !== 8'h8F) begin
      tests_failed++;
      $display("FAIL start_during_mul got dones=%0d cyc=%0d result=%h want 1 17 8f",
               dones, first, res_at_done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit bad;
    issue(2'b01, 8'hFF, 8'h0F);
    wait_done(40, cyc, bad);
    start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (cyc !== 3 || result !== 8'h0F || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_on_done got cyc=%0d result=%h busy=%b done=%b want 3 0f 0 0",
               cyc, result, busy, done);
    end
    issue(2'b10, 8'h05, 8'h07);
    wait_done(40, cyc, bad);
    tests_run++;
    if (cyc !== 4 || bad || result !== 8'hFE) begin
      tests_failed++;
      $display("FAIL sub_after_idle got cyc=%0d bad=%b result=%h want 4 0 fe", cyc, bad, result);
    end
  endtask

  task automatic test_reset_abort();
    int dones = 0;
    int cyc;
    bit bad;
    issue(2'b11, 8'd13, 8'd11);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (done) dones++;
    end
    reset_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, result, zero_o} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL abort_state got busy=%b done=%b result=%h zero=%b want 0 0 00 1",
               busy, done, result, zero_o);
    end
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done got activity=%0d want 0", dones);
    end
    issue(2'b00, 8'h3C, 8'h00);
    wait_done(40, cyc, bad);
    tests_run++;
    if (cyc !== 2 || bad || result !== 8'hC3 || zero_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL not_after_abort got cyc=%0d bad=%b result=%h zero=%b want 2 0 c3 0",
               cyc, bad, result, zero_o);
    end
  endtask

  initial begin
    test_reset();
    test_not();
    test_and();
    test_sub();
    test_mul();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
